// File: rtl/station_agc_ctrl_if.sv
// Front-end control bundle: user buttons and demodulator samples in,
// NCO/CIC configuration and audio mute status out.
interface station_agc_ctrl_if;
    logic        btn_next;
    logic        btn_prev;
    logic        sample_tick;
    logic [15:0] sample_in;
    logic [39:0] phase_inc;
    logic [7:0]  gain;
    logic        mute;
    logic        busy;
    logic [1:0]  preset_idx;

    modport master (
        output btn_next, btn_prev, sample_tick, sample_in,
        input  phase_inc, gain, mute, busy, preset_idx
    );

    modport slave (
        input  btn_next, btn_prev, sample_tick, sample_in,
        output phase_inc, gain, mute, busy, preset_idx
    );
endinterface

// File: rtl/station_agc_ctrl.sv
// Station preset sequencer: mute -> load NCO increment -> settle -> run, with
// windowed peak AGC on the CIC gain when STATION_AGC_CTRL_AGC_EN is defined.
module station_agc_ctrl #(
    parameter logic [39:0] PRESET0      = 40'h98975e5c5,
    parameter logic [39:0] PRESET1      = 40'h5f5e9af9b,
    parameter logic [39:0] PRESET2      = 40'h79c792b11,
    parameter logic [39:0] PRESET3      = 40'h98ead65b7,
    parameter int unsigned MUTE_CYCLES  = 256,
    parameter int unsigned SETTLE_TICKS = 64,
    parameter logic [7:0]  GAIN_INIT    = 8'd0,
    parameter logic [7:0]  GAIN_MAX     = 8'd15,
    parameter int unsigned AGC_WIN      = 256,
    parameter logic [15:0] AGC_HI       = 16'd1536,
    parameter logic [15:0] AGC_LO       = 16'd256
) (
    input  logic              clk,
    input  logic              RST,
    station_agc_ctrl_if.slave bus
);
    localparam int unsigned MW = (MUTE_CYCLES > 1) ? $clog2(MUTE_CYCLES) : 1;
    localparam int unsigned SW = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;
    localparam logic [MW-1:0] MUTE_LAST   = MW'(MUTE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_TICKS - 1);

    typedef enum logic [1:0] {S_RUN, S_MUTE, S_LOAD, S_SETTLE} state_t;

    state_t        state;
    logic [1:0]    preset_idx_r;
    logic [39:0]   phase_inc_r;
    logic          mute_r;
    logic          busy_r;
    logic [MW-1:0] mute_cnt;
    logic [SW-1:0] settle_cnt;

`ifdef STATION_AGC_CTRL_AGC_EN
    localparam int unsigned WW = (AGC_WIN > 1) ? $clog2(AGC_WIN) : 1;
    localparam logic [WW-1:0] WIN_LAST = WW'(AGC_WIN - 1);

    logic [7:0]    gain_r;
    logic [15:0]   peak;
    logic [15:0]   peak_nxt;
    logic [WW-1:0] win_cnt;

    // The closing sample of a window takes part in that window's decision.
    assign peak_nxt = (bus.sample_in > peak) ? bus.sample_in : peak;
    assign bus.gain = gain_r;
`else
    assign bus.gain = GAIN_INIT;
`endif

    function automatic logic [39:0] preset_of(input logic [1:0] idx);
        case (idx)
            2'd0:    return PRESET0;
            2'd1:    return PRESET1;
            2'd2:    return PRESET2;
            default: return PRESET3;
        endcase
    endfunction

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state        <= S_SETTLE;
            preset_idx_r <= '0;
            phase_inc_r  <= PRESET0;
            mute_r       <= 1'b1;
            busy_r       <= 1'b1;
            mute_cnt     <= '0;
            settle_cnt   <= '0;
`ifdef STATION_AGC_CTRL_AGC_EN
            gain_r       <= GAIN_INIT;
            peak         <= '0;
            win_cnt      <= '0;
`endif
        end else begin
            case (state)
                S_RUN: begin
                    // A retune abandons any partial window, so buttons take priority.
                    if (bus.btn_next != bus.btn_prev) begin
                        preset_idx_r <= bus.btn_next ? preset_idx_r + 2'd1 : preset_idx_r - 2'd1;
                        state        <= S_MUTE;
                        mute_r       <= 1'b1;
                        busy_r       <= 1'b1;
                        mute_cnt     <= '0;
                    end
`ifdef STATION_AGC_CTRL_AGC_EN
                    else if (bus.sample_tick) begin
                        if (win_cnt == WIN_LAST) begin
                            if (peak_nxt > AGC_HI && gain_r != 8'd0)
                                gain_r <= gain_r - 8'd1;
                            else if (peak_nxt < AGC_LO && gain_r < GAIN_MAX)
                                gain_r <= gain_r + 8'd1;
                            peak    <= '0;
                            win_cnt <= '0;
                        end else begin
                            peak    <= peak_nxt;
                            win_cnt <= win_cnt + 1'b1;
                        end
                    end
`endif
                end
                S_MUTE: begin
                    if (mute_cnt == MUTE_LAST)
                        state <= S_LOAD;
                    else
                        mute_cnt <= mute_cnt + 1'b1;
                end
                S_LOAD: begin
                    phase_inc_r <= preset_of(preset_idx_r);
                    settle_cnt  <= '0;
                    state       <= S_SETTLE;
`ifdef STATION_AGC_CTRL_AGC_EN
                    gain_r      <= GAIN_INIT;
`endif
                end
                S_SETTLE: begin
                    if (bus.sample_tick) begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state  <= S_RUN;
                            mute_r <= 1'b0;
                            busy_r <= 1'b0;
`ifdef STATION_AGC_CTRL_AGC_EN
                            peak    <= '0;
                            win_cnt <= '0;
`endif
                        end else begin
                            settle_cnt <= settle_cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_SETTLE;
            endcase
        end
    end

    assign bus.phase_inc  = phase_inc_r;
    assign bus.preset_idx = preset_idx_r;
    assign bus.mute       = mute_r;
    assign bus.busy       = busy_r;
endmodule

// File: tb/tb_station_agc_ctrl.sv
// Randomized self-checking bench for station_agc_ctrl against a
// transaction-level model of retune sequencing and windowed AGC.
module tb_station_agc_ctrl;
    localparam int MUTE_N   = 4;
    localparam int SETTLE_N = 3;
    localparam int WIN_N    = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    station_agc_ctrl_if bus();

    station_agc_ctrl #(
        .MUTE_CYCLES (MUTE_N),
        .SETTLE_TICKS(SETTLE_N),
        .AGC_WIN     (WIN_N)
    ) dut (
        .clk(clk),
        .RST(rst),
        .bus(bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [39:0] presets [4];
    logic [1:0]  exp_idx;
    logic [39:0] exp_phase;
    logic [7:0]  exp_gain;
    bit          exp_run;

    task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".phase"}, bus.phase_inc, exp_phase);
        check({tag, ".idx"},   40'(bus.preset_idx), 40'(exp_idx));
        check({tag, ".gain"},  40'(bus.gain), 40'(exp_gain));
        check({tag, ".mute"},  40'(bus.mute), 40'(!exp_run));
        check({tag, ".busy"},  40'(bus.busy), 40'(!exp_run));
    endtask

    // Gain reaction to one completed window, from its peak sample.
    function automatic logic [7:0] next_gain(input logic [7:0] g, input int unsigned pk);
`ifdef STATION_AGC_CTRL_AGC_EN
        if (pk > 1536 && g > 8'd0)  return g - 8'd1;
        if (pk < 256  && g < 8'd15) return g + 8'd1;
`endif
        return g;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc();
    endtask

    task automatic tick(input logic [15:0] v);
        bus.sample_tick = 1'b1;
        bus.sample_in   = v;
        cyc();
        bus.sample_tick = 1'b0;
        bus.sample_in   = 16'($urandom);
    endtask

    task automatic settle();
        for (int i = 0; i < SETTLE_N; i++) begin
            idle($urandom_range(0, 2));
            check_state("settle_wait");
            tick(16'($urandom));
            if (i == SETTLE_N - 1) exp_run = 1'b1;
            check_state("settle_tick");
        end
    endtask

    task automatic window4(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] c, input logic [15:0] d);
        logic [15:0] s [4];
        int unsigned pk;
        s[0] = a; s[1] = b; s[2] = c; s[3] = d;
        pk = 0;
        for (int j = 0; j < WIN_N; j++) begin
            idle($urandom_range(0, 2));
            tick(s[j]);
            if (int'(s[j]) > pk) pk = s[j];
            if (j == WIN_N - 1) begin
                exp_gain = next_gain(exp_gain, pk);
                check_state("win_end");
            end else begin
                check_state("win_mid");
            end
        end
    endtask

    task automatic retune(input bit up, input bit extra_press);
        bus.btn_next = up;
        bus.btn_prev = !up;
        cyc();
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;
        exp_idx = up ? exp_idx + 2'd1 : exp_idx - 2'd1;
        exp_run = 1'b0;
        check_state("retune_enter");
        for (int i = 1; i <= MUTE_N; i++) begin
            if (extra_press && i == 2) bus.btn_next = 1'b1;
            bus.sample_tick = 1'($urandom_range(0, 1));
            bus.sample_in   = 16'($urandom);
            cyc();
            bus.btn_next    = 1'b0;
            bus.sample_tick = 1'b0;
            check_state("retune_mute");
        end
        bus.sample_tick = 1'($urandom_range(0, 1));
        cyc();
        bus.sample_tick = 1'b0;
        exp_phase = presets[exp_idx];
        exp_gain  = 8'd0;
        check_state("retune_load");
        settle();
    endtask

    task automatic random_window();
        logic [15:0] s [4];
        int unsigned lim;
        case ($urandom_range(0, 3))
            0:       lim = 255;
            1:       lim = 1536;
            2:       lim = 256;
            default: lim = 65535;
        endcase
        for (int j = 0; j < 4; j++) s[j] = 16'($urandom_range(0, lim));
        if ($urandom_range(0, 2) == 0) s[$urandom_range(0, 3)] = 16'(lim);
        window4(s[0], s[1], s[2], s[3]);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        presets[0] = 40'h98975e5c5;
        presets[1] = 40'h5f5e9af9b;
        presets[2] = 40'h79c792b11;
        presets[3] = 40'h98ead65b7;
        bus.btn_next    = 1'b0;
        bus.btn_prev    = 1'b0;
        bus.sample_tick = 1'b0;
        bus.sample_in   = '0;
        rst       = 1'b1;
        exp_idx   = 2'd0;
        exp_phase = presets[0];
        exp_gain  = 8'd0;
        exp_run   = 1'b0;

        #12;
        check_state("reset");
        @(negedge clk);
        rst = 1'b0;
        cyc();
        check_state("post_reset");
        settle();

        repeat (17) window4(16'd100, 16'd50, 16'd200, 16'd10);
        repeat (17) window4(16'd0, 16'd2000, 16'd0, 16'd0);

        window4(16'd10, 16'd20, 16'd30, 16'd40);
        window4(16'd1536, 16'd100, 16'd1536, 16'd0);
        window4(16'd256, 16'd256, 16'd3, 16'd256);

        retune(1'b0, 1'b0);
        retune(1'b1, 1'b0);
        retune(1'b1, 1'b0);
        window4(16'd1, 16'd2, 16'd3, 16'd4);

        bus.btn_next = 1'b1;
        bus.btn_prev = 1'b1;
        cyc();
        bus.btn_next = 1'b0;
        bus.btn_prev = 1'b0;
        check_state("both_buttons");

        retune(1'b1, 1'b1);

        tick(16'd3000);
        tick(16'd3000);
        retune(1'b1, 1'b0);
        window4(16'd10, 16'd10, 16'd10, 16'd10);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 7) == 0)
                retune(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                random_window();
        end

        while (exp_idx != 2'd1) retune(1'b1, 1'b0);
        window4(16'd1, 16'd1, 16'd1, 16'd1);
        window4(16'd1, 16'd1, 16'd1, 16'd1);
        bus.btn_next = 1'b1;
        cyc();
        bus.btn_next = 1'b0;
        exp_idx = exp_idx + 2'd1;
        exp_run = 1'b0;
        check_state("pre_rst_mute");
        cyc();
        #2;
        rst = 1'b1;
        #1;
        exp_idx   = 2'd0;
        exp_phase = presets[0];
        exp_gain  = 8'd0;
        check_state("rst_mid_mute");
        idle(2);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        check_state("rst_release");
        settle();
        window4(16'd5, 16'd6, 16'd7, 16'd8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/station_agc_ctrl.md
Name: station_agc_ctrl

Overview:
Controller that sequences the receiver front end: selects one of four preset stations, drives the NCO phase increment and CIC gain, and mutes the PWM audio while the decimation chain flushes after a retune. In RUN it performs a windowed peak-detect AGC on the AM demodulator output by stepping the CIC gain. It sits between user buttons, the NCO/CIC configuration inputs and the demodulator output tick.

Parameters:
PRESET0, 40'h98975e5c5, phase increment for preset 0 (936 kHz)
PRESET1, 40'h5f5e9af9b, phase increment for preset 1 (585 kHz)
PRESET2, 40'h79c792b11, phase increment for preset 2 (747 kHz)
PRESET3, 40'h98ead65b7, phase increment for preset 3
MUTE_CYCLES, 256, clk cycles held muted before loading a new phase increment (>=1)
SETTLE_TICKS, 64, sample ticks discarded after load (>=1)
GAIN_INIT, 8'd0, gain at reset and after every retune
GAIN_MAX, 8'd15, upper gain clamp
AGC_WIN, 256, samples per AGC window (>=1)
AGC_HI, 16'd1536, peak above this: gain decrement
AGC_LO, 16'd256, peak below this: gain increment

Ports:
clk  in  1  system clock
RST  in  1  asynchronous active-high reset
btn_next  in  1  single-cycle pulse, next preset (pre-debounced, synchronous to clk)
btn_prev  in  1  single-cycle pulse, previous preset
sample_tick  in  1  one-cycle strobe, sample_in valid
sample_in  in  16  demodulator output, unsigned magnitude
phase_inc  out  40  NCO phase increment
gain  out  8  CIC gain
mute  out  1  1 = PWM audio forced silent
busy  out  1  1 = retune/settle in progress
preset_idx  out  2  current preset

Behaviour:
- Interface: one clock (clk); reset RST is asynchronous and active-high. All outputs registered.
- Reset: preset_idx=0, phase_inc=PRESET0, gain=GAIN_INIT, mute=1, busy=1, state=SETTLE, all counters and peak=0.
- States: RUN, MUTE, LOAD, SETTLE. mute=busy=1 in all states except RUN (both 0).
- RUN: btn_next alone -> preset_idx+1 mod 4; btn_prev alone -> preset_idx-1 mod 4 (wrap 3->0, 0->3); goes MUTE with mute/busy high after the same edge. Both pulses in the same cycle: ignored, stay RUN. Pulses in any non-RUN state: dropped, not queued.
- MUTE: counts clk cycles; after MUTE_CYCLES cycles in MUTE -> LOAD.
- LOAD (one cycle): phase_inc<=PRESET[preset_idx], gain<=GAIN_INIT, settle count cleared -> SETTLE. Button pulse at edge k gives new phase_inc visible after edge k+MUTE_CYCLES+1.
- SETTLE: counts sample_tick; on the SETTLE_TICKS-th tick -> RUN, mute/busy fall after that edge. AGC window and peak cleared on entry to RUN.
- AGC (RUN only): on each tick peak<=max(peak,sample_in), window count++. On the AGC_WIN-th tick (that sample included in peak) evaluate: peak>AGC_HI and gain>0 -> gain-1; peak<AGC_LO and gain<GAIN_MAX -> gain+1; otherwise hold. Gain changes one clk after that tick; peak and count cleared for the next window. Thresholds strict (peak==AGC_HI or ==AGC_LO: hold). Clamped at 0 and GAIN_MAX, never wraps.
- Leaving RUN abandons the partial window with no gain update. sample_tick ignored in MUTE/LOAD.
- RST asserted mid-operation returns immediately to reset values, including mid-MUTE.

Optional Feature:
STATION_AGC_CTRL_AGC_EN: defined -> AGC as above. Undefined -> peak/window logic not built; gain is GAIN_INIT constant; retune sequencing unchanged.

Test Plan:
(MUTE_CYCLES=4, SETTLE_TICKS=3, AGC_WIN=4, AGC_EN defined)
- Reset release, 3 sample_ticks -> mute/busy stay 1 until the 3rd tick, then 0; phase_inc=40'h98975e5c5, preset_idx=0.
- btn_next pulse at edge k in RUN -> mute=1 after k; phase_inc=40'h5f5e9af9b after k+5; preset_idx=1; mute falls after the 3rd subsequent tick.
- btn_prev at preset 0 -> preset_idx=3, phase_inc=40'h98ead65b7; btn_next+btn_prev same cycle -> no change, mute stays 0.
- Windows of samples {100,50,200,10}: gain 0->1->2 each window up to 15, then holds at 15; samples {0,2000,0,0}: gain decrements by 1 per window, holds at 0.
- Peak exactly 1536 or exactly 256 -> gain unchanged; btn_next during MUTE -> ignored, preset advances only once.
- RST pulse during MUTE -> phase_inc=PRESET0, gain=0, preset_idx=0, mute=1 immediately; AGC_EN undefined build -> gain stays 0 across all sample windows.
